// File: rtl/fullconnect_rd_master.sv
// Avalon-MM read master for a fully connected layer. It fetches Len_i consecutive
// words, starting at BaseAddr_i, over a zero-latency Avalon read port and streams
// them out in order through a small output FIFO.
module fullconnect_rd_master #(
    parameter int AvalonByteEnable_WIDTH = 64,
    parameter int AvalonData_WIDTH       = 512,
    parameter int LEN_WIDTH              = 16,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              Start_i,
    input  logic [63:0]                       BaseAddr_i,
    input  logic [LEN_WIDTH-1:0]              Len_i,
    output logic                              Busy_o,
    output logic                              Done_o,
    output logic [63:0]                       RdMstAddr_o,
    output logic                              RdMstRead_o,
    output logic                              RdMstWrite_o,
    output logic [AvalonByteEnable_WIDTH-1:0] RdMstByteEnable_o,
    output logic [AvalonData_WIDTH-1:0]       RdMstWriteData_o,
    input  logic [AvalonData_WIDTH-1:0]       RdMstReadData_i,
    output logic                              RdMstLock_o,
    input  logic                              RdMstWaitReq_i,
    output logic [AvalonData_WIDTH-1:0]       StrmData_o,
    output logic                              StrmValid_o,
    input  logic                              StrmReady_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [63:0]   STRIDE_C = 64'(AvalonByteEnable_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [63:0]                 addr_q, addr_d;
    logic [LEN_WIDTH-1:0]        remaining_q, remaining_d;
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q;
    logic [AvalonData_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic rd_req;
    logic accept;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    // Reads are only requested while there is room, so a granted word always fits.
    assign rd_req     = (state_q == S_READ) && !fifo_full;
    assign accept     = rd_req && !RdMstWaitReq_i;
    assign pop        = !fifo_empty && StrmReady_i;

    // Next-state logic: latch the request in IDLE, count words down in READ,
    // wait for the FIFO to empty in DRAIN, pulse DONE for one cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (Start_i) begin
                    addr_d      = BaseAddr_i;
                    remaining_d = Len_i;
                    state_d     = (Len_i != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (accept) begin
                    addr_d      = addr_q + STRIDE_C;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The cycle that pops the last word already counts as empty.
                if (fifo_empty || ((count_q == CW'(1)) && pop)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage, no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= RdMstReadData_i;
        end
    end

    assign Busy_o            = (state_q != S_IDLE);
    assign Done_o            = (state_q == S_DONE);
    assign RdMstAddr_o       = addr_q;
    assign RdMstRead_o       = rd_req;
    assign RdMstWrite_o      = 1'b0;
    assign RdMstByteEnable_o = '1;
    assign RdMstWriteData_o  = '0;
    assign RdMstLock_o       = 1'b0;
    assign StrmValid_o       = !fifo_empty;
    // Gate the head so the stream bus reads zero while nothing is buffered.
    assign StrmData_o        = fifo_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fullconnect_rd_master.sv
// Scoreboard bench for fullconnect_rd_master: expected addresses and stream words
// are queued when a transfer is started; a monitor pops and compares them.
module tb_fullconnect_rd_master;

    localparam int BW = 64;
    localparam int DW = 512;
    localparam int LW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [63:0]   base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done;
    logic [63:0]   rd_addr;
    logic          rd_read, rd_write, rd_lock;
    logic [BW-1:0] rd_be;
    logic [DW-1:0] rd_wdata, rd_data;
    logic          waitreq = 1'b0;
    logic [DW-1:0] strm_data;
    logic          strm_valid;
    logic          ready = 1'b0;

    always #5 clk = ~clk;

    fullconnect_rd_master #(
        .AvalonByteEnable_WIDTH(BW),
        .AvalonData_WIDTH(DW),
        .LEN_WIDTH(LW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .Start_i(start),
        .BaseAddr_i(base_addr),
        .Len_i(len),
        .Busy_o(busy),
        .Done_o(done),
        .RdMstAddr_o(rd_addr),
        .RdMstRead_o(rd_read),
        .RdMstWrite_o(rd_write),
        .RdMstByteEnable_o(rd_be),
        .RdMstWriteData_o(rd_wdata),
        .RdMstReadData_i(rd_data),
        .RdMstLock_o(rd_lock),
        .RdMstWaitReq_i(waitreq),
        .StrmData_o(strm_data),
        .StrmValid_o(strm_valid),
        .StrmReady_i(ready)
    );

    // Memory model: contents are a fixed function of the byte address.
    function automatic logic [DW-1:0] word_of(input logic [63:0] a);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 64; k++) begin
            w[k*64 +: 64] = (a * 64'(k + 3)) ^ 64'h5A5A_0F0F_C3C3_9696 ^ {a[31:0], a[63:32]};
        end
        return w;
    endfunction

    assign rd_data = word_of(rd_addr);

    logic [63:0]   exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    bit rand_en = 1'b0;
    int wait_pct = 0;
    int rdy_pct = 100;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Random Avalon slave stall and stream backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) begin
                waitreq = ($urandom_range(99) < wait_pct);
                ready   = ($urandom_range(99) < rdy_pct);
            end
        end
    end

    // Monitor: scoreboard pops plus hold-stability checks.
    logic          prev_rd = 1'b0, prev_wait = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [63:0]   prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_rd = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_rd && prev_wait) begin
                    chk("rd_hold", DW'(rd_read), DW'(1));
                    chk("addr_hold", DW'(rd_addr), DW'(prev_addr));
                end
                if (prev_valid && !prev_ready) begin
                    chk("valid_hold", DW'(strm_valid), DW'(1));
                    chk("data_hold", strm_data, prev_data);
                end
                if (rd_read && !waitreq) begin
                    acc_cnt++;
                    if (exp_addr_q.size() == 0) chk("unexpected_read", DW'(rd_addr), '1);
                    else chk("rd_addr", DW'(rd_addr), DW'(exp_addr_q.pop_front()));
                end
                if (strm_valid && ready) begin
                    if (exp_data_q.size() == 0) chk("unexpected_word", strm_data, '1);
                    else chk("strm_data", strm_data, exp_data_q.pop_front());
                end
                prev_rd    = rd_read;
                prev_wait  = waitreq;
                prev_addr  = rd_addr;
                prev_valid = strm_valid;
                prev_ready = ready;
                prev_data  = strm_data;
            end
        end
    end

    // Issue one start pulse; queue the words the transfer must produce.
    task automatic start_xfer(input logic [63:0] b, input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        len = LW'(n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(b + 64'(i) * 64'(BW));
            exp_data_q.push_back(word_of(b + 64'(i) * 64'(BW)));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = {$urandom, $urandom};
        len = LW'($urandom);
        @(negedge clk);
        chk("busy_after_start", DW'(busy), DW'(1));
        chk("first_read", DW'(rd_read), DW'(n != 0));
        if (n != 0) chk("first_addr", DW'(rd_addr), DW'(b));
    endtask

    // Wait (bounded) for the completion pulse and check the return to idle.
    task automatic wait_done();
        int cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            chk("done_timeout", DW'(done), DW'(1));
            exp_addr_q.delete();
            exp_data_q.delete();
        end else begin
            chk("addr_left", DW'(exp_addr_q.size()), '0);
            chk("data_left", DW'(exp_data_q.size()), '0);
            @(negedge clk);
            chk("done_one_cycle", DW'(done), '0);
            chk("busy_after_done", DW'(busy), '0);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"}, DW'(busy), '0);
        chk({nm, "_done"}, DW'(done), '0);
        chk({nm, "_read"}, DW'(rd_read), '0);
        chk({nm, "_valid"}, DW'(strm_valid), '0);
        chk({nm, "_addr"}, DW'(rd_addr), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int cyc;
        logic [63:0] b;

        // Reset state and constant outputs.
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("write_const", DW'(rd_write), '0);
        chk("lock_const", DW'(rd_lock), '0);
        chk("be_const", DW'(rd_be), DW'({BW{1'b1}}));
        chk("wdata_const", rd_wdata, '0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("post_reset");

        // Basic read.
        waitreq = 1'b0;
        ready = 1'b1;
        start_xfer(64'h1000, 3);
        wait_done();

        // Wait states on the only read.
        waitreq = 1'b1;
        a0 = acc_cnt;
        start_xfer(64'h3000, 1);
        repeat (4) begin
            @(negedge clk);
            chk("ws_read", DW'(rd_read), DW'(1));
            chk("ws_addr", DW'(rd_addr), DW'(64'h3000));
        end
        @(posedge clk);
        #1;
        waitreq = 1'b0;
        wait_done();
        chk("ws_accepts", DW'(acc_cnt - a0), DW'(1));

        // Backpressure fills the FIFO and stops reads.
        ready = 1'b0;
        a0 = acc_cnt;
        start_xfer(64'h20000, 8);
        repeat (10) @(negedge clk);
        chk("bp_accepts", DW'(acc_cnt - a0), DW'(FD));
        chk("bp_read_low", DW'(rd_read), '0);
        chk("bp_valid", DW'(strm_valid), DW'(1));
        @(posedge clk);
        #1;
        ready = 1'b1;
        wait_done();
        chk("bp_total", DW'(acc_cnt - a0), DW'(8));

        // Zero length.
        a0 = acc_cnt;
        start_xfer(64'h7000, 0);
        chk("zl_done", DW'(done), DW'(1));
        wait_done();
        chk("zl_no_read", DW'(acc_cnt - a0), '0);

        // Start while busy is ignored; address wraps modulo 2^64.
        waitreq = 1'b1;
        start_xfer(64'hFFFF_FFFF_FFFF_FFC0, 2);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 64'h5000;
        len = LW'(9);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_start_addr", DW'(rd_addr), DW'(64'hFFFF_FFFF_FFFF_FFC0));
        @(posedge clk);
        #1;
        waitreq = 1'b0;
        wait_done();

        // Reset in the middle of a transfer.
        ready = 1'b0;
        a0 = acc_cnt;
        start_xfer(64'h4000, 6);
        cyc = 0;
        while ((acc_cnt - a0) < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        #2;
        rstn = 1'b0;
        #1;
        chk_idle_outputs("mid_reset");
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        chk_idle_outputs("no_restart");
        a0 = acc_cnt;
        start_xfer(64'h0, 1);
        wait_done();
        chk("after_reset_reads", DW'(acc_cnt - a0), DW'(1));

        // Randomized transfers.
        rand_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            wait_pct = $urandom_range(60);
            rdy_pct = $urandom_range(100, 20);
            b = {$urandom, $urandom} & ~64'(BW - 1);
            if (t % 5 == 0) b = 64'hFFFF_FFFF_FFFF_FF00;
            start_xfer(b, $urandom_range(10));
            wait_done();
        end
        rand_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
